// File: rtl/mem_access_unit_if.sv
// Memory-side bus of the load/store unit: one request held until a single-cycle ack.
interface mem_access_unit_if;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [BW-1:0] bus_be;
  logic [DW-1:0] bus_wdata;
  logic [DW-1:0] bus_rdata;
  logic          bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: lane steering, load extension and a stall handshake to the bus.
// Define MEM_TIMEOUT_EN to abort accesses that wait TIMEOUT_CYCLES cycles without an ack.
module mem_access_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic                     reg_write,
  input  logic [31:0]              addr,
  input  logic [31:0]              wdata,
  input  logic [1:0]               size,
  input  logic                     sign,
  mem_access_unit_if.master        bus,
  output logic                     stall,
  output logic                     o_write,
  output logic [1:0]               o_quarter,
  output logic [31:0]              o_rdata,
  output logic                     misalign,
  output logic                     bus_err
);

  localparam int unsigned DW = 32;
  localparam int unsigned BW = DW / 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_nx;

  logic          is_access_c;
  logic          misaligned_c;
  logic          issue_c;
  logic          ack_c;
  logic          timeout_c;
  logic [BW-1:0] be_c;
  logic [DW-1:0] wdata_c;

  logic          acc_load_q;
  logic          acc_reg_write_q;
  logic [1:0]    acc_size_q;
  logic          acc_sign_q;
  logic [1:0]    acc_quarter_q;
  logic          abort_q;
  logic [DW-1:0] rdata_q;

  // Shift the addressed lane down, then extend from the access width.
  function automatic logic [DW-1:0] extract_load(input logic [DW-1:0] rd,
                                                 input logic [1:0]    quarter,
                                                 input logic [1:0]    sz,
                                                 input logic          sg);
    logic [DW-1:0] sh;
    sh = rd >> {quarter, 3'b000};
    case (sz)
      SZ_BYTE: extract_load = sg ? {{24{sh[7]}}, sh[7:0]}   : {24'h0, sh[7:0]};
      SZ_HALF: extract_load = sg ? {{16{sh[15]}}, sh[15:0]} : {16'h0, sh[15:0]};
      default: extract_load = rd;
    endcase
  endfunction

  assign is_access_c = mem_read | mem_write;
  assign issue_c     = (state == ST_IDLE) && is_access_c && !misaligned_c;
  assign ack_c       = (state == ST_WAIT) && bus.bus_ack;

  // Byte enables, store lane replication and alignment check for the request in IDLE.
  always_comb begin
    be_c         = 4'b1111;
    wdata_c      = wdata;
    misaligned_c = 1'b0;
    case (size)
      SZ_BYTE: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be_c         = addr[1] ? 4'b1100 : 4'b0011;
        wdata_c      = {2{wdata[15:0]}};
        misaligned_c = addr[0];
      end
      default: misaligned_c = (addr[1:0] != 2'b00);
    endcase
  end

`ifdef MEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;

  // An ack on the final allowed cycle still completes the access normally.
  assign timeout_c = (state == ST_WAIT) && !bus.bus_ack &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= '0;
    end else if ((state == ST_WAIT) && (state_nx == ST_WAIT)) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  // The watchdog is absent; the parameter stays for a uniform instantiation interface.
  assign timeout_c = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus the pipeline-facing outputs.
  always_comb begin
    state_nx  = state;
    stall     = 1'b0;
    o_write   = 1'b0;
    o_quarter = acc_quarter_q;
    o_rdata   = '0;
    case (state)
      ST_IDLE: begin
        o_quarter = addr[1:0];
        if (issue_c) begin
          stall    = 1'b1;
          state_nx = ST_WAIT;
        end else begin
          o_write = reg_write & ~is_access_c;
        end
      end
      ST_WAIT: begin
        stall = 1'b1;
        if (ack_c || timeout_c) begin
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        o_write  = acc_load_q & acc_reg_write_q & ~abort_q;
        o_rdata  = extract_load(rdata_q, acc_quarter_q, acc_size_q, acc_sign_q);
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Bus request registers and the access context captured at issue.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.bus_req     <= 1'b0;
      bus.bus_we      <= 1'b0;
      bus.bus_addr    <= '0;
      bus.bus_be      <= '0;
      bus.bus_wdata   <= '0;
      rdata_q         <= '0;
      misalign        <= 1'b0;
      bus_err         <= 1'b0;
      acc_load_q      <= 1'b0;
      acc_reg_write_q <= 1'b0;
      acc_size_q      <= '0;
      acc_sign_q      <= 1'b0;
      acc_quarter_q   <= '0;
      abort_q         <= 1'b0;
    end else begin
      misalign <= (state == ST_IDLE) && is_access_c && misaligned_c;
      bus_err  <= timeout_c;
      if (issue_c) begin
        bus.bus_req     <= 1'b1;
        bus.bus_we      <= mem_write;
        bus.bus_addr    <= {addr[31:2], 2'b00};
        bus.bus_be      <= be_c;
        bus.bus_wdata   <= wdata_c;
        acc_load_q      <= ~mem_write;
        acc_reg_write_q <= reg_write;
        acc_size_q      <= size;
        acc_sign_q      <= sign;
        acc_quarter_q   <= addr[1:0];
        abort_q         <= 1'b0;
      end else if (ack_c) begin
        bus.bus_req <= 1'b0;
        rdata_q     <= bus.bus_rdata;
      end else if (timeout_c) begin
        bus.bus_req <= 1'b0;
        rdata_q     <= '0;
        abort_q     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table, directed corner sequences, random traffic.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        mem_read, mem_write, reg_write, sign;
  logic [31:0] addr, wdata;
  logic [1:0]  size;
  logic        stall, o_write, misalign, bus_err;
  logic [1:0]  o_quarter;
  logic [31:0] o_rdata;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .reg_write (reg_write),
    .addr      (addr),
    .wdata     (wdata),
    .size      (size),
    .sign      (sign),
    .bus       (bus_if),
    .stall     (stall),
    .o_write   (o_write),
    .o_quarter (o_quarter),
    .o_rdata   (o_rdata),
    .misalign  (misalign),
    .bus_err   (bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rd, wr, rw;
    logic [31:0] a;
    logic [1:0]  sz;
    logic        e_stall, e_write;
    logic [1:0]  e_q;
    logic        e_mis;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: widths in bytes and plain arithmetic on lanes.
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] ref_be(input logic [31:0] a, input logic [1:0] sz);
    int n = nbytes(sz);
    int off = int'(a % 4);
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] wd, input logic [1:0] sz);
    logic [31:0] r;
    int n = nbytes(sz);
    for (int k = 0; k < 4; k++) r[8*k +: 8] = wd[8*(k % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] rd, input logic [31:0] a,
                                           input logic [1:0] sz, input logic sg);
    longint v;
    int n = nbytes(sz);
    int off = int'(a % 4);
    if (n == 4) return rd;
    v = longint'(rd >> (8 * off)) & ((longint'(1) << (8 * n)) - 1);
    if (sg && (((v >> (8 * n - 1)) & 1) == 1)) v = v - (longint'(1) << (8 * n));
    return 32'(v);
  endfunction

  task automatic drive_idle();
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;
    addr = '0; wdata = '0; size = 2'b00; sign = 1'b0;
  endtask

  task automatic drive_random();
    int op;
    op = int'($urandom_range(0, 3));
    mem_read  = (op == 1) || (op == 3);
    mem_write = (op == 2) || (op == 3);
    reg_write = 1'($urandom_range(0, 1));
    addr      = $urandom();
    wdata     = $urandom();
    size      = 2'($urandom_range(0, 3));
    sign      = 1'($urandom_range(0, 1));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stall_cnt, req_cnt, err_cnt, err_at, exp_mis, d, n, off;
    logic c_rd, c_wr, c_rw, c_sg, acc, mis;
    logic [31:0] c_a, c_wd, rd_exp;
    logic [1:0]  c_sz;

    // ---------------- reset state ----------------
    rst = 1'b1;
    drive_idle();
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = '0;
    #3;
    chk("rst_bus_req",   32'(bus_if.bus_req), 0);
    chk("rst_bus_we",    32'(bus_if.bus_we), 0);
    chk("rst_bus_addr",  bus_if.bus_addr, 0);
    chk("rst_bus_be",    32'(bus_if.bus_be), 0);
    chk("rst_bus_wdata", bus_if.bus_wdata, 0);
    chk("rst_misalign",  32'(misalign), 0);
    chk("rst_bus_err",   32'(bus_err), 0);
    chk("rst_stall",     32'(stall), 0);
    tick();
    rst = 1'b0;

    // ---------------- single-cycle vectors: non-memory ops and misaligned accesses ----------------
    vecs[0] = '{1'b0, 1'b0, 1'b1, 32'h0000_0002, 2'b10, 1'b0, 1'b1, 2'd2, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b0, 32'h0000_0001, 2'b00, 1'b0, 1'b0, 2'd1, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 32'h0000_3001, 2'b10, 1'b0, 1'b0, 2'd1, 1'b1};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 32'h0000_0005, 2'b01, 1'b0, 1'b0, 2'd1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0002, 2'b10, 1'b0, 1'b0, 2'd2, 1'b1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 32'h0000_0003, 2'b11, 1'b0, 1'b0, 2'd3, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 1'b1, 32'h0000_0003, 2'b01, 1'b0, 1'b0, 2'd3, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b1, 32'hFFFF_FFF3, 2'b01, 1'b0, 1'b1, 2'd3, 1'b0};
    for (int i = 0; i < 8; i++) begin
      tick();
      mem_read = vecs[i].rd; mem_write = vecs[i].wr; reg_write = vecs[i].rw;
      addr = vecs[i].a; size = vecs[i].sz; sign = 1'b1; wdata = 32'h1234_5678;
      @(negedge clk);
      chk($sformatf("vec%0d_stall", i),   32'(stall), 32'(vecs[i].e_stall));
      chk($sformatf("vec%0d_o_write", i), 32'(o_write), 32'(vecs[i].e_write));
      chk($sformatf("vec%0d_o_quarter", i), 32'(o_quarter), 32'(vecs[i].e_q));
      chk($sformatf("vec%0d_o_rdata", i), o_rdata, 0);
      tick();
      drive_idle();
      @(negedge clk);
      chk($sformatf("vec%0d_misalign", i), 32'(misalign), 32'(vecs[i].e_mis));
      chk($sformatf("vec%0d_bus_req", i),  32'(bus_if.bus_req), 0);
    end

    // ---------------- signed byte load at 0x1003, ack on 2nd WAIT cycle, early ack ignored ----------------
    stall_cnt = 0;
    tick();
    mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; addr = 32'h0000_1003;
    size = 2'b00; sign = 1'b1; wdata = 32'h5555_5555;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    if (stall) stall_cnt++;
    chk("lb_issue_bus_req", 32'(bus_if.bus_req), 0);
    tick();
    bus_if.bus_ack = 1'b0;
    mem_read = 1'b0; addr = 32'h0000_FFFF; sign = 1'b0; size = 2'b10; reg_write = 1'b0;
    @(negedge clk);
    if (stall) stall_cnt++;
    chk("lb_bus_req",  32'(bus_if.bus_req), 1);
    chk("lb_bus_be",   32'(bus_if.bus_be), 32'h8);
    chk("lb_bus_addr", bus_if.bus_addr, 32'h0000_1000);
    chk("lb_bus_we",   32'(bus_if.bus_we), 0);
    tick();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h8011_2233;
    @(negedge clk);
    if (stall) stall_cnt++;
    chk("lb_wait2_bus_req", 32'(bus_if.bus_req), 1);
    tick();
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    if (stall) stall_cnt++;
    chk("lb_done_stall",     32'(stall), 0);
    chk("lb_done_o_write",   32'(o_write), 1);
    chk("lb_done_o_quarter", 32'(o_quarter), 3);
    chk("lb_done_o_rdata",   o_rdata, 32'hFFFF_FF80);
    chk("lb_done_bus_req",   32'(bus_if.bus_req), 0);
    tick();
    drive_idle();
    @(negedge clk);
    if (stall) stall_cnt++;
    chk("lb_stall_cycles", 32'(stall_cnt), 3);

    // ---------------- half store at 0x2002 with read also asserted: the write wins ----------------
    tick();
    mem_read = 1'b1; mem_write = 1'b1; reg_write = 1'b1; addr = 32'h0000_2002;
    size = 2'b01; sign = 1'b0; wdata = 32'h0000_ABCD;
    @(negedge clk);
    chk("sh_issue_stall", 32'(stall), 1);
    tick();
    drive_idle();
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("sh_bus_we",    32'(bus_if.bus_we), 1);
    chk("sh_bus_be",    32'(bus_if.bus_be), 32'hC);
    chk("sh_bus_wdata", bus_if.bus_wdata, 32'hABCD_ABCD);
    chk("sh_bus_addr",  bus_if.bus_addr, 32'h0000_2000);
    tick();
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    chk("sh_done_o_write", 32'(o_write), 0);
    chk("sh_done_stall",   32'(stall), 0);

    // ---------------- reset while waiting, then a late ack ----------------
    tick();
    mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; addr = 32'h0000_4002;
    size = 2'b01; sign = 1'b0;
    tick();
    drive_idle();
    @(negedge clk);
    chk("rw_bus_req_before", 32'(bus_if.bus_req), 1);
    #1 rst = 1'b1;
    #1;
    chk("rw_bus_req_async", 32'(bus_if.bus_req), 0);
    chk("rw_bus_be_async",  32'(bus_if.bus_be), 0);
    chk("rw_stall_async",   32'(stall), 0);
    tick();
    rst = 1'b0;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h0000_7777;
    @(negedge clk);
    chk("rw_late_bus_req",   32'(bus_if.bus_req), 0);
    chk("rw_late_stall",     32'(stall), 0);
    chk("rw_late_o_write",   32'(o_write), 0);
    chk("rw_late_o_quarter", 32'(o_quarter), 0);
    tick();
    bus_if.bus_ack = 1'b0;
    @(negedge clk);
    chk("rw_after_o_write", 32'(o_write), 0);
    chk("rw_after_o_rdata", o_rdata, 0);

`ifdef MEM_TIMEOUT_EN
    // ---------------- watchdog abort with no ack ----------------
    tick();
    mem_read = 1'b1; mem_write = 1'b0; reg_write = 1'b1; addr = 32'h0000_5000;
    size = 2'b10; sign = 1'b0;
    req_cnt = 0; err_cnt = 0; err_at = 0;
    for (int c = 1; c <= 8; c++) begin
      tick();
      drive_idle();
      bus_if.bus_ack = 1'b0;
      @(negedge clk);
      if (bus_if.bus_req) req_cnt++;
      if (bus_err) begin
        err_cnt++;
        err_at = c;
        chk("to_o_write", 32'(o_write), 0);
        chk("to_o_rdata", o_rdata, 0);
        chk("to_stall",   32'(stall), 0);
      end
    end
    chk("to_req_cycles", 32'(req_cnt), 4);
    chk("to_err_pulses", 32'(err_cnt), 1);
    chk("to_err_cycle",  32'(err_at), 5);
`endif

    // ---------------- random traffic against the reference model ----------------
    exp_mis = 0;
    for (int t = 0; t < 300; t++) begin
      tick();
      drive_random();
      bus_if.bus_ack = 1'($urandom_range(0, 1));
      bus_if.bus_rdata = $urandom();
      c_rd = mem_read; c_wr = mem_write; c_rw = reg_write; c_a = addr;
      c_wd = wdata; c_sz = size; c_sg = sign;
      @(negedge clk);
      chk("rnd_misalign", 32'(misalign), 32'(exp_mis));
      chk("rnd_bus_err",  32'(bus_err), 0);
      acc = c_rd | c_wr;
      n   = nbytes(c_sz);
      off = int'(c_a % 4);
      mis = acc && ((c_a % n) != 0);
      exp_mis = int'(mis);
      if (!acc) begin
        chk("rnd_nm_stall",     32'(stall), 0);
        chk("rnd_nm_o_write",   32'(o_write), 32'(c_rw));
        chk("rnd_nm_o_quarter", 32'(o_quarter), 32'(off));
        chk("rnd_nm_o_rdata",   o_rdata, 0);
      end else if (mis) begin
        chk("rnd_mis_stall",   32'(stall), 0);
        chk("rnd_mis_o_write", 32'(o_write), 0);
        chk("rnd_mis_bus_req", 32'(bus_if.bus_req), 0);
      end else begin
        chk("rnd_iss_stall", 32'(stall), 1);
        d = int'($urandom_range(1, 3));
        rd_exp = '0;
        for (int w = 1; w <= d; w++) begin
          tick();
          drive_random();
          bus_if.bus_ack = (w == d);
          bus_if.bus_rdata = $urandom();
          if (w == d) rd_exp = bus_if.bus_rdata;
          @(negedge clk);
          chk("rnd_w_bus_req",   32'(bus_if.bus_req), 1);
          chk("rnd_w_bus_we",    32'(bus_if.bus_we), 32'(c_wr));
          chk("rnd_w_bus_addr",  bus_if.bus_addr, c_a & 32'hFFFF_FFFC);
          chk("rnd_w_bus_be",    32'(bus_if.bus_be), 32'(ref_be(c_a, c_sz)));
          chk("rnd_w_bus_wdata", bus_if.bus_wdata, ref_wdata(c_wd, c_sz));
          chk("rnd_w_stall",     32'(stall), 1);
          chk("rnd_w_misalign",  32'(misalign), 0);
        end
        tick();
        drive_random();
        bus_if.bus_ack = 1'($urandom_range(0, 1));
        bus_if.bus_rdata = $urandom();
        @(negedge clk);
        chk("rnd_d_stall",     32'(stall), 0);
        chk("rnd_d_bus_req",   32'(bus_if.bus_req), 0);
        chk("rnd_d_o_write",   32'(o_write), 32'(!c_wr && c_rw));
        chk("rnd_d_o_quarter", 32'(o_quarter), 32'(off));
        if (!c_wr) chk("rnd_d_o_rdata", o_rdata, ref_load(rd_exp, c_a, c_sz, c_sg));
        exp_mis = 0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 15, meaning the maximum number of bus wait cycles before abort (used only with MEM_TIMEOUT_EN).
REQ-002 SHALL have ports:
- clk  in  1  single clock, all state updates on posedge.
- rst  in  1  asynchronous active-high reset.
- mem_read  in  1  load request from EX/MEM.
- mem_write  in  1  store request from EX/MEM.
- reg_write  in  1  instruction writes the register file.
- addr  in  32  byte address.
- wdata  in  32  store data, right-justified.
- size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- sign  in  1  sign-extend load result.
- bus_req  out  1  memory request.
- bus_we  out  1  store request.
- bus_addr  out  32  word address, {addr[31:2],2'b00}.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-replicated store data.
- bus_rdata  in  32  read data, valid with bus_ack.
- bus_ack  in  1  one-cycle completion strobe.
- stall  out  1  freeze upstream stages and the MEM/WB latch.
- o_write  out  1  register write enable to MEM/WB.
- o_quarter  out  2  byte lane to MEM/WB; equals addr[1:0] of the access.
- o_rdata  out  32  extracted and extended load data.
- misalign  out  1  one-cycle misaligned-access flag.
- bus_err  out  1  one-cycle timeout flag.

Function
REQ-003 SHALL implement the FSM states IDLE, WAIT and DONE.
REQ-004 In IDLE with neither mem_read nor mem_write: stall=0; o_write=reg_write, o_quarter=addr[1:0] and o_rdata=0 combinationally; zero latency.
REQ-005 In IDLE with an aligned access: stall=1 combinationally; bus_addr, bus_be, bus_wdata and bus_we are registered at posedge; bus_req=1 from the next cycle; next state WAIT.
REQ-006 In WAIT: bus_req, bus_addr, bus_be, bus_wdata and bus_we SHALL be held stable and stall=1; when bus_ack is sampled high, bus_rdata is captured, bus_req drops next cycle and the FSM goes to DONE.
REQ-007 In DONE, exactly one cycle: stall=0; o_write=reg_write for loads and 0 for stores; o_quarter and o_rdata come from the captured values; next state IDLE. Minimum access latency is 3 cycles (IDLE, WAIT with ack, DONE).
REQ-008 Byte enables: byte -> 4'b0001<<addr[1:0]; half -> 4'b0011 if addr[1]=0, else 4'b1100; word -> 4'b1111.
REQ-009 Store replication: byte -> {4{wdata[7:0]}}; half -> {2{wdata[15:0]}}; word -> wdata.
REQ-010 Load extraction: shift bus_rdata right by 8*addr[1:0], then zero-extend (sign=0) or sign-extend (sign=1) from 8 or 16 bits; word loads pass through unchanged.
REQ-011 A misaligned access (half with addr[0]=1, or word with addr[1:0]!=0) SHALL issue no bus request, pulse misalign for one cycle, force o_write=0 and keep stall=0.
REQ-012 When mem_read and mem_write are both 1, the write wins; the access is a store and o_write=0.
REQ-013 bus_ack SHALL be ignored outside WAIT, including an ack in the same cycle the request is registered.
REQ-014 Inputs SHALL be sampled only in IDLE; input changes in WAIT or DONE have no effect on the access in flight.

Reset
REQ-015 When rst is asserted, asynchronously: state=IDLE, bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, captured rdata=0, misalign=0, bus_err=0 and the timeout counter=0.
REQ-016 Reset during WAIT SHALL drop bus_req immediately; a late bus_ack after reset is ignored.

Configuration
REQ-017 With MEM_TIMEOUT_EN defined:
- A counter SHALL count WAIT cycles.
- If it reaches TIMEOUT_CYCLES without bus_ack: bus_req drops, bus_err pulses for one cycle, and the FSM enters DONE with o_write=0 and o_rdata=0.
REQ-018 Without MEM_TIMEOUT_EN: WAIT lasts indefinitely, bus_err is tied to 0, and no counter is present.

Verification
REQ-019 Load byte, addr=0x1003, sign=1, bus_rdata=0x80112233, ack on the 2nd WAIT cycle -> bus_be=1000; o_rdata=0xFFFFFF80, o_quarter=3, o_write=1 in DONE; stall high for exactly 3 cycles.
REQ-020 Store half, addr=0x2002, wdata=0x0000ABCD -> bus_we=1, bus_be=1100, bus_wdata=0xABCDABCD; o_write=0.
REQ-021 Load word, addr=0x3001 -> no bus_req, misalign=1 for one cycle, stall=0, o_write=0.
REQ-022 Non-memory op, reg_write=1, addr=0x0002 -> stall=0, o_write=1, o_quarter=2 in the same cycle.
REQ-023 rst asserted in WAIT, then bus_ack one cycle later -> bus_req=0 immediately, FSM in IDLE, no DONE cycle, ack ignored.
REQ-024 With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack -> bus_req drops after 4 WAIT cycles, bus_err pulses once, o_write=0, then IDLE.
